sram_bytemask: RTL and testbench
================================

Name: sram_bytemask

Overview:
Parametrised single-port synchronous SRAM, successor to the fixed 32-bit on-chip memory. Adds:
- configurable width, depth and read latency
- per-byte write enables
- a ready/valid handshake
- a hardware clear sequencer that zeroes the array after reset
- an out-of-range error flag

It sits between the core's load/store unit and on-chip storage, as instruction or data memory.

Parameters:
ADDRESS_WIDTH, 15, address bus width in bits.
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
DEPTH, 1 << ADDRESS_WIDTH, number of words implemented; may be less than 2^ADDRESS_WIDTH.
READ_LATENCY, 1, cycles from accepted read to dataValid; legal values 1 or 2.
CLEAR_ON_RESET, 1, when 1, the array is zeroed by the clear sequencer after reset.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
enable  in  1  request strobe.
readWrite  in  1  1 = read, 0 = write.
byteEnable  in  DATA_WIDTH/8  write byte mask; bit i covers dataIn[8i+7:8i].
address  in  ADDRESS_WIDTH  word address.
dataIn  in  DATA_WIDTH  write data.
ready  out  1  block can accept a request this cycle.
dataOut  out  DATA_WIDTH  read data.
dataValid  out  1  one-cycle pulse: dataOut carries read result.
error  out  1  one-cycle pulse: out-of-range access.

Behaviour:
- Reset values while reset is high: dataOut=0, dataValid=0, error=0, read pipeline cleared, clear counter=0. ready=0 when CLEAR_ON_RESET=1; ready=1 when CLEAR_ON_RESET=0. Memory contents are not reset directly.
- FSM states: CLEAR, IDLE.
  - After reset with CLEAR_ON_RESET=1: enter CLEAR.
  - With CLEAR_ON_RESET=0: enter IDLE.
- CLEAR state:
  - Writes 0 to word at counter, counter increments by one per clock.
  - After writing DEPTH-1 (DEPTH cycles total), go to IDLE; ready rises on the following clock.
  - ready=0 throughout CLEAR. enable is ignored and dropped, with no error.
- Reset asserted mid-CLEAR or mid-read aborts everything. Pending dataValid/error pulses are discarded. CLEAR restarts at address 0.
- Accept rule: a request is accepted on a rising edge where enable=1 and ready=1. In IDLE, ready stays 1, so one request per cycle is sustained back-to-back.
- Write (readWrite=0, address<DEPTH):
  - For each i with byteEnable[i]=1, memory[address] byte i <= dataIn byte i. Other bytes are unchanged.
  - byteEnable=0 is a legal no-op.
  - No dataValid pulse.
- Read (readWrite=1, address<DEPTH):
  - dataOut = memory[address] and dataValid=1 exactly READ_LATENCY cycles after the accepting edge.
  - byteEnable is ignored.
- Read-after-write: a read of the same address accepted on the cycle after a write returns the new data, since the write completes on its accepting edge.
- Out-of-range (address >= DEPTH):
  - No array access.
  - Read: dataValid=1, dataOut=0 and error=1 in the same cycle, READ_LATENCY cycles after acceptance.
  - Write: error=1 on the cycle after acceptance; memory is unchanged.
- dataOut holds its last read value when dataValid=0; it is not zeroed between reads.
- Pipelined reads with READ_LATENCY=2 keep request order. Each accepted read produces exactly one dataValid pulse.
- error and dataValid are single-cycle pulses, never stretched.

Test Plan:
1. Clear sequencing: DEPTH=16, CLEAR_ON_RESET=1; release reset and read all 16 words after ready -> ready=0 for exactly 16 cycles, then 1; every read returns 0x00000000 with one dataValid per read.
2. Byte mask: write 0xAABBCCDD, byteEnable=4'b1111 to addr 3; then write 0x11223344, byteEnable=4'b0101 to addr 3; read addr 3 -> 0xAA22CC44.
3. Latency and order: READ_LATENCY=2, four back-to-back reads of addr 0..3 holding 0x10..0x13 -> dataValid high 4 consecutive cycles starting 2 cycles after the first accept; dataOut sequence 0x10,0x11,0x12,0x13.
4. Out-of-range: DEPTH=16, ADDRESS_WIDTH=5; write 0xFFFFFFFF to addr 20, then read addr 20 -> error pulse after the write with no dataValid; read gives dataValid=1, error=1, dataOut=0; addr 4 is unchanged.
5. Read-after-write: write 0x12345678 to addr 7, then read addr 7 on the next cycle -> dataOut=0x12345678.
6. Reset mid-clear: assert reset at clear counter=5, release -> ready=0 for a full DEPTH cycles again; enable asserted during CLEAR produces no write, no dataValid, no error.

Source files
------------

// File: rtl/sram_bytemask.sv
// Single-port synchronous SRAM: per-byte write enables, ready/valid handshake,
// post-reset clear sequencer, 1- or 2-cycle read latency, out-of-range flag.
module sram_bytemask #(
    parameter int ADDRESS_WIDTH  = 15,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 1 << ADDRESS_WIDTH,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      readWrite,
    input  logic [DATA_WIDTH/8-1:0]   byteEnable,
    input  logic [ADDRESS_WIDTH-1:0]  address,
    input  logic [DATA_WIDTH-1:0]     dataIn,
    output logic                      ready,
    output logic [DATA_WIDTH-1:0]     dataOut,
    output logic                      dataValid,
    output logic                      error
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_W  = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t state, state_n;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      clr_cnt;

    logic                  accept, out_of_range, rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_idx;
    logic [BYTES-1:0]      mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  s1_valid, s1_err;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  fin_valid, fin_err;
    logic [DATA_WIDTH-1:0] fin_data;

    // Request decode and read-path selection.
    always_comb begin
        ready        = (state == IDLE);
        accept       = enable & ready & ~reset;
        out_of_range = ({1'b0, address} >= DEPTH_W);
        rd_acc       = accept & readWrite;
        wr_acc       = accept & ~readWrite;
        rd_word      = out_of_range ? '0 : mem[address[IDX_W-1:0]];
        // Latency 1 feeds the output registers straight from the accepting
        // edge; latency 2 inserts the s1 stage in front of them.
        if (READ_LATENCY == 1) begin
            fin_valid = rd_acc;
            fin_err   = rd_acc & out_of_range;
            fin_data  = rd_word;
        end else begin
            fin_valid = s1_valid;
            fin_err   = s1_err;
            fin_data  = s1_data;
        end
    end

    // Next-state logic and array write-port steering (clear has priority).
    always_comb begin
        state_n   = state;
        mem_we    = 1'b0;
        mem_idx   = address[IDX_W-1:0];
        mem_be    = byteEnable;
        mem_wdata = dataIn;
        case (state)
            CLEAR: begin
                mem_we    = ~reset;
                mem_idx   = clr_cnt;
                mem_be    = '1;
                mem_wdata = '0;
                if (clr_cnt == LAST_IDX) begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                mem_we = wr_acc & ~out_of_range;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? CLEAR : IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Clear counter, read pipeline and output pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_cnt   <= '0;
            s1_valid  <= 1'b0;
            s1_err    <= 1'b0;
            s1_data   <= '0;
            dataValid <= 1'b0;
            error     <= 1'b0;
            dataOut   <= '0;
        end else begin
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            s1_valid  <= rd_acc;
            s1_err    <= rd_acc & out_of_range;
            s1_data   <= rd_word;
            dataValid <= fin_valid;
            error     <= fin_err | (wr_acc & out_of_range);
            if (fin_valid) begin
                dataOut <= fin_data;
            end
        end
    end

    // Byte-masked array write; storage itself is never reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_bytemask.sv
// Directed bench: DUT a (DEPTH=16, 5-bit address, latency 2, clear on reset)
// and DUT b (DEPTH=16, 5-bit address, latency 1, no clear).
module tb_sram_bytemask;

    logic        clock = 1'b0;
    logic        reset;

    logic        en, rw;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        rdy, dv, err;
    logic [31:0] dout;

    logic        en_b, rw_b;
    logic [3:0]  be_b;
    logic [4:0]  addr_b;
    logic [31:0] din_b;
    logic        rdy_b, dv_b, err_b;
    logic [31:0] dout_b;

    int vectors = 0;
    int miscompares = 0;

    logic [4:0]  rd_addr [16];
    logic [31:0] rd_exp  [16];
    logic        rd_eerr [16];

    sram_bytemask #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (32),
        .DEPTH         (16),
        .READ_LATENCY  (2),
        .CLEAR_ON_RESET(1'b1)
    ) dut_a (
        .clock     (clock),
        .reset     (reset),
        .enable    (en),
        .readWrite (rw),
        .byteEnable(be),
        .address   (addr),
        .dataIn    (din),
        .ready     (rdy),
        .dataOut   (dout),
        .dataValid (dv),
        .error     (err)
    );

    sram_bytemask #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (32),
        .DEPTH         (16),
        .READ_LATENCY  (1),
        .CLEAR_ON_RESET(1'b0)
    ) dut_b (
        .clock     (clock),
        .reset     (reset),
        .enable    (en_b),
        .readWrite (rw_b),
        .byteEnable(be_b),
        .address   (addr_b),
        .dataIn    (din_b),
        .ready     (rdy_b),
        .dataOut   (dout_b),
        .dataValid (dv_b),
        .error     (err_b)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task step;
        @(posedge clock);
        #1;
    endtask

    task write_a(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        en = 1'b1; rw = 1'b0; addr = a; din = d; be = m;
        step();
        en = 1'b0;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL write_err addr=%0d: got %b want 0", a, err);
        end
    endtask

    // Back-to-back reads of rd_addr[0..n-1]; latency-2 result for accept k
    // is sampled after step k+1.
    task run_reads(input int n);
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) begin
                en = 1'b1; rw = 1'b1; addr = rd_addr[k]; be = 4'h0;
            end else begin
                en = 1'b0;
            end
            step();
            vectors++;
            if (k >= 1 && k <= n) begin
                if (dv !== 1'b1 || dout !== rd_exp[k-1] || err !== rd_eerr[k-1]) begin
                    miscompares++;
                    $display("FAIL read addr=%0d: got dv=%b data=%h err=%b want dv=1 data=%h err=%b",
                             rd_addr[k-1], dv, dout, err, rd_exp[k-1], rd_eerr[k-1]);
                end
            end else if (dv !== 1'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL read_idle step=%0d: got dv=%b err=%b want 0 0", k, dv, err);
            end
        end
        en = 1'b0;
    endtask

    task test_reset;
        vectors++;
        if (rdy !== 1'b0 || dv !== 1'b0 || err !== 1'b0 || dout !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_a: got rdy=%b dv=%b err=%b data=%h want 0 0 0 0", rdy, dv, err, dout);
        end
        vectors++;
        if (rdy_b !== 1'b1 || dv_b !== 1'b0 || err_b !== 1'b0 || dout_b !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_b: got rdy=%b dv=%b err=%b data=%h want 1 0 0 0", rdy_b, dv_b, err_b, dout_b);
        end
    endtask

    task test_clear;
        int n;
        reset = 1'b0;
        n = 0;
        while (rdy === 1'b0 && n < 100) begin
            n++;
            step();
        end
        vectors++;
        if (n !== 16) begin
            miscompares++;
            $display("FAIL clear_len: got %0d cycles not ready want 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr[i] = 5'(i); rd_exp[i] = 32'h0; rd_eerr[i] = 1'b0;
        end
        run_reads(16);
    endtask

    task test_byte_mask;
        write_a(5'd3, 32'hAABBCCDD, 4'b1111);
        write_a(5'd3, 32'h11223344, 4'b0101);
        rd_addr[0] = 5'd3; rd_exp[0] = 32'hAA22CC44; rd_eerr[0] = 1'b0;
        run_reads(1);
        write_a(5'd3, 32'hFFFFFFFF, 4'b0000);
        run_reads(1);
    endtask

    task test_latency_order;
        for (int i = 0; i < 4; i++) begin
            write_a(5'(i), 32'h10 + 32'(i), 4'hF);
        end
        for (int i = 0; i < 4; i++) begin
            rd_addr[i] = 5'(i); rd_exp[i] = 32'h10 + 32'(i); rd_eerr[i] = 1'b0;
        end
        run_reads(4);
    endtask

    task test_out_of_range;
        write_a(5'd4, 32'hCAFE0004, 4'hF);
        en = 1'b1; rw = 1'b0; addr = 5'd20; din = 32'hFFFFFFFF; be = 4'hF;
        step();
        en = 1'b0;
        vectors++;
        if (err !== 1'b1 || dv !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_write: got err=%b dv=%b want 1 0", err, dv);
        end
        step();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_write_pulse: got err=%b want 0", err);
        end
        rd_addr[0] = 5'd20; rd_exp[0] = 32'h0;       rd_eerr[0] = 1'b1;
        rd_addr[1] = 5'd4;  rd_exp[1] = 32'hCAFE0004; rd_eerr[1] = 1'b0;
        run_reads(2);
        step();
        vectors++;
        if (dout !== 32'hCAFE0004 || dv !== 1'b0) begin
            miscompares++;
            $display("FAIL data_hold: got data=%h dv=%b want cafe0004 0", dout, dv);
        end
    endtask

    task test_read_after_write;
        write_a(5'd7, 32'h12345678, 4'hF);
        rd_addr[0] = 5'd7; rd_exp[0] = 32'h12345678; rd_eerr[0] = 1'b0;
        run_reads(1);
    endtask

    task test_reset_mid_clear;
        int n;
        reset = 1'b1;
        step();
        reset = 1'b0;
        en = 1'b1; addr = 5'd0; din = 32'hDEADBEEF; be = 4'hF;
        for (int k = 0; k < 5; k++) begin
            rw = k[0];
            step();
            vectors++;
            if (rdy !== 1'b0 || dv !== 1'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL clear1_quiet k=%0d: got rdy=%b dv=%b err=%b want 0 0 0", k, rdy, dv, err);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        while (rdy === 1'b0 && n < 100) begin
            rw = n[0];
            n++;
            step();
            vectors++;
            if (dv !== 1'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL clear2_quiet n=%0d: got dv=%b err=%b want 0 0", n, dv, err);
            end
        end
        en = 1'b0;
        vectors++;
        if (n !== 16) begin
            miscompares++;
            $display("FAIL clear_restart_len: got %0d want 16", n);
        end
        rd_addr[0] = 5'd0; rd_exp[0] = 32'h0; rd_eerr[0] = 1'b0;
        rd_addr[1] = 5'd4; rd_exp[1] = 32'h0; rd_eerr[1] = 1'b0;
        run_reads(2);
    endtask

    task test_latency1;
        en_b = 1'b1; rw_b = 1'b0; addr_b = 5'd7; din_b = 32'h12345678; be_b = 4'hF;
        step();
        rw_b = 1'b1;
        vectors++;
        if (err_b !== 1'b0 || dv_b !== 1'b0) begin
            miscompares++;
            $display("FAIL b_write: got err=%b dv=%b want 0 0", err_b, dv_b);
        end
        step();
        en_b = 1'b0;
        vectors++;
        if (dv_b !== 1'b1 || dout_b !== 32'h12345678 || err_b !== 1'b0) begin
            miscompares++;
            $display("FAIL b_raw: got dv=%b data=%h err=%b want 1 12345678 0", dv_b, dout_b, err_b);
        end
        step();
        vectors++;
        if (dv_b !== 1'b0 || dout_b !== 32'h12345678) begin
            miscompares++;
            $display("FAIL b_hold: got dv=%b data=%h want 0 12345678", dv_b, dout_b);
        end
        en_b = 1'b1; rw_b = 1'b0; din_b = 32'hFFFFFFFF; be_b = 4'b1010;
        step();
        rw_b = 1'b1;
        step();
        en_b = 1'b0;
        vectors++;
        if (dv_b !== 1'b1 || dout_b !== 32'hFF34FF78) begin
            miscompares++;
            $display("FAIL b_mask: got dv=%b data=%h want 1 ff34ff78", dv_b, dout_b);
        end
        en_b = 1'b1; rw_b = 1'b1; addr_b = 5'd20;
        step();
        en_b = 1'b0;
        vectors++;
        if (dv_b !== 1'b1 || err_b !== 1'b1 || dout_b !== 32'h0) begin
            miscompares++;
            $display("FAIL b_oor_read: got dv=%b err=%b data=%h want 1 1 0", dv_b, err_b, dout_b);
        end
        en_b = 1'b1; rw_b = 1'b0;
        step();
        en_b = 1'b0;
        vectors++;
        if (dv_b !== 1'b0 || err_b !== 1'b1) begin
            miscompares++;
            $display("FAIL b_oor_write: got dv=%b err=%b want 0 1", dv_b, err_b);
        end
        step();
        vectors++;
        if (err_b !== 1'b0) begin
            miscompares++;
            $display("FAIL b_err_pulse: got err=%b want 0", err_b);
        end
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0; rw = 1'b0; be = 4'h0; addr = '0; din = '0;
        en_b = 1'b0; rw_b = 1'b0; be_b = 4'h0; addr_b = '0; din_b = '0;
        repeat (3) step();
        test_reset();
        test_clear();
        test_byte_mask();
        test_latency_order();
        test_out_of_range();
        test_read_after_write();
        test_reset_mid_clear();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
